// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Control sequencer for the multicycle RISC core. It owns the state register,
// decodes the instruction held in the IR and drives every datapath mux select
// and enable for FETCH -> DECODE -> EXEC -> MEM -> WB. It also handles
// conditional ADD/NAND writeback (carry/zero), memory wait states and the
// LM/SM multi-register loop.
//
// Only state, multi_idx and illegal are registered. Every other output is
// decoded combinationally from the current state and the IR fields. While
// reset_i is high, all outputs are forced to their idle values.
//
// Ports
//   clk_i          clock; all state updates occur on the rising edge
//   reset_i        synchronous, active-high reset
//   ir_i           current instruction register contents
//   carry_flag_i   stored C flag
//   zero_flag_i    stored Z flag
//   alu_eq_i       ALU operands are equal (BEQ)
//   mem_ready_i    memory has completed the current read or write
//   ir_we_o        load IR from memory data
//   pc_we_o        load PC
//   mem_rd_o       memory read request
//   mem_wr_o       memory write request
//   rf_we_o        register-file write enable
//   rf_wa_sel_o    RF write address: 0=IR[11:9] 1=IR[8:6] 2=IR[5:3] 3=multi_idx
//   rf_wd_sel_o    RF write data:    0=ALU 1=mem data 2=PC 3=LHI immediate
//   alu_a_sel_o    ALU A input:      0=PC 1=regA 2=T1
//   alu_b_sel_o    ALU B input:      0=regB 1=const 1 2=sext6 3=sext9
//   alu_op_o       ALU function:     0=add 1=nand 2=sub/compare
//   cz_we_o        update the C/Z flags
//   multi_idx_o    current LM/SM register index
//   state_o        encoded state, for debug (FETCH = 0)
//   illegal_o      sticky flag; set when an undefined opcode is decoded
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int IR_W    = 16,
    parameter int RA_W    = 3,
    parameter int MULTI_W = 8
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [IR_W-1:0] ir_i,
    input  logic            carry_flag_i,
    input  logic            zero_flag_i,
    input  logic            alu_eq_i,
    input  logic            mem_ready_i,
    output logic            ir_we_o,
    output logic            pc_we_o,
    output logic            mem_rd_o,
    output logic            mem_wr_o,
    output logic            rf_we_o,
    output logic [1:0]      rf_wa_sel_o,
    output logic [1:0]      rf_wd_sel_o,
    output logic [1:0]      alu_a_sel_o,
    output logic [1:0]      alu_b_sel_o,
    output logic [1:0]      alu_op_o,
    output logic            cz_we_o,
    output logic [RA_W-1:0] multi_idx_o,
    output logic [4:0]      state_o,
    output logic            illegal_o
);

    typedef enum logic [4:0] {
        S_FETCH    = 5'd0,
        S_DECODE   = 5'd1,
        S_EXR      = 5'd2,
        S_WB_R     = 5'd3,
        S_EXI      = 5'd4,
        S_WB_I     = 5'd5,
        S_WB_LHI   = 5'd6,
        S_MADDR    = 5'd7,
        S_MRD      = 5'd8,
        S_WB_MEM   = 5'd9,
        S_MWR      = 5'd10,
        S_MINIT    = 5'd11,
        S_MSCAN    = 5'd12,
        S_MXFER    = 5'd13,
        S_MINC     = 5'd14,
        S_BCMP     = 5'd15,
        S_BTAKE    = 5'd16,
        S_JAL_LINK = 5'd17,
        S_JAL_JUMP = 5'd18,
        S_JLR_LINK = 5'd19,
        S_JLR_JUMP = 5'd20
    } state_e;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADI  = 4'b0001;
    localparam logic [3:0] OP_NAND = 4'b0010;
    localparam logic [3:0] OP_LHI  = 4'b0011;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_LM   = 4'b0110;
    localparam logic [3:0] OP_SM   = 4'b0111;
    localparam logic [3:0] OP_JAL  = 4'b1000;
    localparam logic [3:0] OP_JLR  = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1100;

    localparam logic [RA_W-1:0] LAST_IDX = RA_W'(MULTI_W - 1);

    state_e            state_q;
    logic [RA_W-1:0]   multi_idx_q;
    logic              illegal_q;

    logic [3:0]         opcode;
    logic [1:0]         cond;
    logic [MULTI_W-1:0] bitmap;
    logic               cond_ok;
    logic               is_lm;
    logic               last_idx;

    assign opcode   = ir_i[IR_W-1 -: 4];
    assign cond     = ir_i[1:0];
    assign bitmap   = ir_i[MULTI_W-1:0];
    assign is_lm    = (opcode == OP_LM);
    assign last_idx = (multi_idx_q == LAST_IDX);

    // cond 2'b11 is trapped as illegal before this is consulted.
    assign cond_ok = (cond == 2'b00) ||
                     (cond == 2'b10 && carry_flag_i) ||
                     (cond == 2'b01 && zero_flag_i);

    // -------------------------------------------------------------------------
    // State sequencing
    // -------------------------------------------------------------------------
    // NOTE: every register in this block uses non-blocking assignment. Each
    // branch then sees the values from before the clock edge, regardless of
    // the order in which the statements are written.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_FETCH;
            multi_idx_q <= '0;
            illegal_q   <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ready_i) state_q <= S_DECODE;
                end
                S_DECODE: begin
                    case (opcode)
                        OP_ADD, OP_NAND: begin
                            if (cond == 2'b11) begin
                                illegal_q <= 1'b1;
                                state_q   <= S_FETCH;
                            end else begin
                                // A failed condition retires the instruction
                                // with no flag or register update.
                                state_q <= cond_ok ? S_EXR : S_FETCH;
                            end
                        end
                        OP_ADI:        state_q <= S_EXI;
                        OP_LHI:        state_q <= S_WB_LHI;
                        OP_LW, OP_SW:  state_q <= S_MADDR;
                        OP_LM, OP_SM:  state_q <= S_MINIT;
                        OP_BEQ:        state_q <= S_BCMP;
                        OP_JAL:        state_q <= S_JAL_LINK;
                        OP_JLR:        state_q <= S_JLR_LINK;
                        default: begin
                            illegal_q <= 1'b1;
                            state_q   <= S_FETCH;
                        end
                    endcase
                end
                S_EXR:      state_q <= S_WB_R;
                S_WB_R:     state_q <= S_FETCH;
                S_EXI:      state_q <= S_WB_I;
                S_WB_I:     state_q <= S_FETCH;
                S_WB_LHI:   state_q <= S_FETCH;
                S_MADDR:    state_q <= (opcode == OP_LW) ? S_MRD : S_MWR;
                S_MRD: begin
                    if (mem_ready_i) state_q <= S_WB_MEM;
                end
                S_WB_MEM:   state_q <= S_FETCH;
                S_MWR: begin
                    if (mem_ready_i) state_q <= S_FETCH;
                end
                S_MINIT: begin
                    multi_idx_q <= '0;
                    state_q     <= S_MSCAN;
                end
                S_MSCAN: begin
                    // Set bits detour through MXFER/MINC. MINC then advances
                    // the index itself, so only clear bits step the index here.
                    if (bitmap[multi_idx_q]) begin
                        state_q <= S_MXFER;
                    end else if (last_idx) begin
                        state_q <= S_FETCH;
                    end else begin
                        multi_idx_q <= multi_idx_q + 1'b1;
                    end
                end
                S_MXFER: begin
                    if (mem_ready_i) state_q <= S_MINC;
                end
                S_MINC: begin
                    if (last_idx) begin
                        state_q <= S_FETCH;
                    end else begin
                        multi_idx_q <= multi_idx_q + 1'b1;
                        state_q     <= S_MSCAN;
                    end
                end
                S_BCMP:     state_q <= alu_eq_i ? S_BTAKE : S_FETCH;
                S_BTAKE:    state_q <= S_FETCH;
                S_JAL_LINK: state_q <= S_JAL_JUMP;
                S_JAL_JUMP: state_q <= S_FETCH;
                S_JLR_LINK: state_q <= S_JLR_JUMP;
                S_JLR_JUMP: state_q <= S_FETCH;
                default:    state_q <= S_FETCH;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    // NOTE: every output gets a default value before the case statement, so
    // any state that leaves a signal untouched still drives it. Without the
    // defaults, synthesis would infer latches to hold the old value.
    always_comb begin
        ir_we_o     = 1'b0;
        pc_we_o     = 1'b0;
        mem_rd_o    = 1'b0;
        mem_wr_o    = 1'b0;
        rf_we_o     = 1'b0;
        rf_wa_sel_o = 2'd0;
        rf_wd_sel_o = 2'd0;
        alu_a_sel_o = 2'd0;
        alu_b_sel_o = 2'd0;
        alu_op_o    = 2'd0;
        cz_we_o     = 1'b0;
        if (!reset_i) begin
            case (state_q)
                S_FETCH: begin
                    // PC + 1 is computed every cycle, but IR and PC load only
                    // when the fetch completes.
                    mem_rd_o    = 1'b1;
                    alu_b_sel_o = 2'd1;
                    ir_we_o     = mem_ready_i;
                    pc_we_o     = mem_ready_i;
                end
                S_EXR: begin
                    alu_a_sel_o = 2'd1;
                    alu_op_o    = (opcode == OP_NAND) ? 2'd1 : 2'd0;
                    cz_we_o     = 1'b1;
                end
                S_WB_R: begin
                    rf_we_o     = 1'b1;
                    rf_wa_sel_o = 2'd2;
                end
                S_EXI: begin
                    alu_a_sel_o = 2'd1;
                    alu_b_sel_o = 2'd2;
                    cz_we_o     = 1'b1;
                end
                S_WB_I: begin
                    rf_we_o     = 1'b1;
                    rf_wa_sel_o = 2'd1;
                end
                S_WB_LHI: begin
                    rf_we_o     = 1'b1;
                    rf_wd_sel_o = 2'd3;
                end
                S_MADDR: begin
                    // Effective address = register operand + sext6; T1 holds it.
                    alu_a_sel_o = 2'd1;
                    alu_b_sel_o = 2'd2;
                end
                S_MRD:    mem_rd_o = 1'b1;
                S_WB_MEM: begin
                    rf_we_o     = 1'b1;
                    rf_wd_sel_o = 2'd1;
                    cz_we_o     = 1'b1;
                end
                S_MWR:    mem_wr_o = 1'b1;
                S_MINIT:  alu_a_sel_o = 2'd1;   // T1 <= regA
                S_MXFER: begin
                    mem_rd_o    = is_lm;
                    mem_wr_o    = !is_lm;
                    rf_we_o     = is_lm && mem_ready_i;
                    rf_wa_sel_o = 2'd3;
                    rf_wd_sel_o = 2'd1;
                end
                S_MINC: begin
                    alu_a_sel_o = 2'd2;
                    alu_b_sel_o = 2'd1;
                end
                S_BCMP: begin
                    alu_a_sel_o = 2'd1;
                    alu_op_o    = 2'd2;
                end
                S_BTAKE: begin
                    pc_we_o     = 1'b1;
                    alu_b_sel_o = 2'd2;
                end
                S_JAL_LINK, S_JLR_LINK: begin
                    rf_we_o     = 1'b1;
                    rf_wd_sel_o = 2'd2;
                end
                S_JAL_JUMP: begin
                    pc_we_o     = 1'b1;
                    alu_b_sel_o = 2'd3;
                end
                // The datapath masks A to zero here, so PC <= regB.
                S_JLR_JUMP: pc_we_o = 1'b1;
                default: ;
            endcase
        end
    end

    assign multi_idx_o = multi_idx_q;
    assign state_o     = state_q;
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
//
// Drives directed cases and random instructions into multicycle_control_fsm.
// Each instruction's observed cycle count and per-signal activity counts are
// compared with a reference model. The model works from instruction
// semantics: how many memory transactions the instruction needs, how many
// register writes it makes, and so on. A reactive memory stalls each request
// for a chosen number of cycles.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

    localparam int IR_W    = 16;
    localparam int RA_W    = 3;
    localparam int MULTI_W = 8;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic [IR_W-1:0] ir_i;
    logic            carry_flag_i, zero_flag_i, alu_eq_i, mem_ready_i;
    logic            ir_we_o, pc_we_o, mem_rd_o, mem_wr_o, rf_we_o, cz_we_o;
    logic [1:0]      rf_wa_sel_o, rf_wd_sel_o, alu_a_sel_o, alu_b_sel_o, alu_op_o;
    logic [RA_W-1:0] multi_idx_o;
    logic [4:0]      state_o;
    logic            illegal_o;

    multicycle_control_fsm #(.IR_W(IR_W), .RA_W(RA_W), .MULTI_W(MULTI_W)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .ir_i(ir_i),
        .carry_flag_i(carry_flag_i), .zero_flag_i(zero_flag_i),
        .alu_eq_i(alu_eq_i), .mem_ready_i(mem_ready_i),
        .ir_we_o(ir_we_o), .pc_we_o(pc_we_o), .mem_rd_o(mem_rd_o),
        .mem_wr_o(mem_wr_o), .rf_we_o(rf_we_o), .rf_wa_sel_o(rf_wa_sel_o),
        .rf_wd_sel_o(rf_wd_sel_o), .alu_a_sel_o(alu_a_sel_o),
        .alu_b_sel_o(alu_b_sel_o), .alu_op_o(alu_op_o), .cz_we_o(cz_we_o),
        .multi_idx_o(multi_idx_o), .state_o(state_o), .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Observed activity for one instruction.
    int n_cyc, n_rf, n_cz, n_pc, n_rd, n_wr, n_viol, n_rf_cz, max_wr_run;
    int idx_log [8];
    logic [1:0] last_wa, br_bsel;
    // Reference model state.
    bit model_ill = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected activity, computed from instruction semantics.
    // w = stall cycles before mem_ready for every memory transaction.
    task automatic model(input logic [15:0] ir, input bit c, input bit z, input bit eq,
                         input int w, output int cyc, output int rf, output int cz,
                         output int pc, output int rd, output int wr);
        logic [3:0] op;
        logic [1:0] cnd;
        int t, p;
        op  = ir[15:12];
        cnd = ir[1:0];
        t   = w + 1;
        p   = $countones(ir[7:0]);
        cyc = t + 1; rd = t; pc = 1; rf = 0; cz = 0; wr = 0;   // fetch + decode
        case (op)
            4'h0, 4'h2: begin
                if (cnd == 2'b11) model_ill = 1'b1;
                else if ((cnd == 2'b10 && !c) || (cnd == 2'b01 && !z)) ;
                else begin cyc += 2; rf = 1; cz = 1; end
            end
            4'h1: begin cyc += 2; rf = 1; cz = 1; end
            4'h3: begin cyc += 1; rf = 1; end
            4'h4: begin cyc += t + 2; rd += t; rf = 1; cz = 1; end
            4'h5: begin cyc += t + 1; wr = t; end
            4'h6: begin cyc += 1 + MULTI_W + p * (t + 1); rd += p * t; rf = p; end
            4'h7: begin cyc += 1 + MULTI_W + p * (t + 1); wr = p * t; end
            4'hC: begin cyc += 1 + int'(eq); pc += int'(eq); end
            4'h8, 4'h9: begin cyc += 2; rf = 1; pc += 1; end
            default: model_ill = 1'b1;
        endcase
    endtask

    // Runs one instruction. Call it just after a falling edge with the DUT in
    // FETCH; it returns at the falling edge where FETCH is re-entered.
    task automatic run_instr(input logic [15:0] ir, input bit c, input bit z,
                             input bit eq, input int w);
        int  wait_cnt = 0, wr_run = 0;
        bit  left_fetch = 0, done = 0, prev_stall = 0;
        logic prev_rd = 0, prev_wr = 0;
        ir_i = ir; carry_flag_i = c; zero_flag_i = z; alu_eq_i = eq;
        n_cyc = 0; n_rf = 0; n_cz = 0; n_pc = 0; n_rd = 0; n_wr = 0;
        n_viol = 0; n_rf_cz = 0; max_wr_run = 0; last_wa = 2'd0; br_bsel = 2'd0;
        for (int i = 0; i < 8; i++) idx_log[i] = -1;
        while (!done && n_cyc < 400) begin
            if (mem_rd_o || mem_wr_o) begin
                if (wait_cnt < w) begin mem_ready_i = 1'b0; wait_cnt++; end
                else begin mem_ready_i = 1'b1; wait_cnt = 0; end
            end else begin
                mem_ready_i = 1'($urandom_range(0, 1));
            end
            #1;
            n_cyc++;
            if (rf_we_o) begin
                if (n_rf < 8) idx_log[n_rf] = int'(multi_idx_o);
                n_rf++;
                last_wa = rf_wa_sel_o;
            end
            if (cz_we_o) n_cz++;
            if (rf_we_o && cz_we_o) n_rf_cz++;
            if (pc_we_o) begin
                n_pc++;
                if (state_o != 5'd0) br_bsel = alu_b_sel_o;
            end
            if (mem_rd_o) n_rd++;
            if (mem_wr_o) begin
                n_wr++; wr_run++;
                if (wr_run > max_wr_run) max_wr_run = wr_run;
            end else wr_run = 0;
            if (mem_rd_o && mem_wr_o) n_viol++;
            if (prev_stall && (mem_rd_o !== prev_rd || mem_wr_o !== prev_wr)) n_viol++;
            prev_stall = (mem_rd_o || mem_wr_o) && !mem_ready_i;
            prev_rd = mem_rd_o;
            prev_wr = mem_wr_o;
            if (state_o != 5'd0) left_fetch = 1;
            @(negedge clk_i);
            if (left_fetch && state_o == 5'd0) done = 1;
        end
    endtask

    // Runs an instruction and compares every counter with the model.
    task automatic run_and_check(input string tag, input logic [15:0] ir, input bit c,
                                 input bit z, input bit eq, input int w);
        int e_cyc, e_rf, e_cz, e_pc, e_rd, e_wr;
        model(ir, c, z, eq, w, e_cyc, e_rf, e_cz, e_pc, e_rd, e_wr);
        run_instr(ir, c, z, eq, w);
        check($sformatf("%s ir=%h cycles", tag, ir), n_cyc, e_cyc);
        check($sformatf("%s ir=%h rf_we", tag, ir), n_rf, e_rf);
        check($sformatf("%s ir=%h cz_we", tag, ir), n_cz, e_cz);
        check($sformatf("%s ir=%h pc_we", tag, ir), n_pc, e_pc);
        check($sformatf("%s ir=%h mem_rd", tag, ir), n_rd, e_rd);
        check($sformatf("%s ir=%h mem_wr", tag, ir), n_wr, e_wr);
        check($sformatf("%s ir=%h mem_protocol", tag, ir), n_viol, 0);
        check($sformatf("%s ir=%h illegal", tag, ir), illegal_o, model_ill);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ops [16];
        logic [15:0] rnd_ir;
        logic [11:0] low;

        // ---------------- reset ----------------
        reset_i = 1'b1; ir_i = 16'h0000; carry_flag_i = 0; zero_flag_i = 0;
        alu_eq_i = 0; mem_ready_i = 0;
        repeat (2) @(negedge clk_i);
        #1;
        check("reset state", state_o, 5'd0);
        check("reset mem_rd gated", mem_rd_o, 1'b0);
        check("reset alu_b_sel", alu_b_sel_o, 2'd0);
        check("reset illegal", illegal_o, 1'b0);
        check("reset multi_idx", multi_idx_o, 3'd0);
        reset_i = 1'b0;
        #1;
        check("post-reset fetch mem_rd", mem_rd_o, 1'b1);
        check("post-reset fetch alu_b_sel", alu_b_sel_o, 2'd1);
        check("fetch stall pc_we", pc_we_o, 1'b0);

        // ---------------- directed ----------------
        run_and_check("ADD", 16'h0298, 0, 0, 0, 0);
        check("ADD rf_wa_sel", last_wa, 2'd2);
        check("ADD rf_we/cz_we disjoint", n_rf_cz, 0);

        run_and_check("ADC C=0", 16'h029A, 0, 1, 0, 0);
        run_and_check("ADC C=1", 16'h029A, 1, 0, 0, 1);
        run_and_check("ADZ Z=0", 16'h0299, 1, 0, 0, 0);

        run_and_check("LM", 16'h6005, 0, 0, 0, 0);
        check("LM first idx", idx_log[0], 0);
        check("LM second idx", idx_log[1], 2);
        check("LM final idx", multi_idx_o, 3'd7);
        check("LM rf_wa_sel", last_wa, 2'd3);

        run_and_check("SM empty", 16'h7000, 0, 0, 0, 2);

        run_and_check("SW stall3", 16'h5283, 0, 0, 0, 3);
        check("SW mem_wr run", max_wr_run, 4);

        run_and_check("BEQ taken", 16'hC283, 0, 0, 1, 0);
        check("BEQ btake alu_b_sel", br_bsel, 2'd2);
        run_and_check("BEQ not taken", 16'hC283, 0, 0, 0, 0);

        run_and_check("ILL 1111", 16'hF000, 0, 0, 0, 0);
        run_and_check("ADD after ill", 16'h0298, 0, 0, 0, 0);

        // Reset during an LW memory wait.
        ir_i = 16'h4283; mem_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        mem_ready_i = 1'b0;
        #1;
        check("LW wait mem_rd", mem_rd_o, 1'b1);
        @(negedge clk_i);
        #1;
        check("LW wait mem_rd held", mem_rd_o, 1'b1);
        check("LW wait not fetch", state_o != 5'd0, 1'b1);
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        model_ill = 1'b0;
        #1;
        check("rst-in-MRD state", state_o, 5'd0);
        check("rst-in-MRD mem_rd", mem_rd_o, 1'b1);
        check("rst-in-MRD multi_idx", multi_idx_o, 3'd0);
        check("rst-in-MRD illegal", illegal_o, 1'b0);

        // ---------------- random ----------------
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                4'h8, 4'h9, 4'hC, 4'h0, 4'h2, 4'h6, 4'hA, 4'hF};
        for (int n = 0; n < 60; n++) begin
            low    = 12'($urandom());
            rnd_ir = {ops[$urandom_range(0, 15)], low};
            run_and_check("RND", rnd_ir, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
